phy_rx_packet_tagger: RTL and testbench



---
 rtl/phy_rx_packet_tagger.sv | 255 +++++++++++++++++++++++++
 tb/tb_phy_rx_packet_tagger.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_packet_tagger.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_packet_tagger
// Brief    : Classifies PHY receive packets as DLLP or TLP, validates DLLP
//            framing and emits one tagged AXI-Stream. Optional statistics
//            counters are built when PHY_RX_TAGGER_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
module phy_rx_packet_tagger #(
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = 4,
    parameter int MAX_TLP_BEATS = 1031
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  phy_link_up_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic [15:0]           dllp_drop_cnt_o,
    output logic [15:0]           tlp_err_cnt_o
);

    localparam int                     c_cnt_w      = $clog2(MAX_TLP_BEATS + 2);
    localparam logic [c_cnt_w-1:0]     c_max_beats  = c_cnt_w'(MAX_TLP_BEATS);
    localparam logic [USER_WIDTH-1:0]  c_user_dllp  = USER_WIDTH'(3'b001);
    localparam logic [USER_WIDTH-1:0]  c_user_tlp   = USER_WIDTH'(3'b010);
    localparam logic [USER_WIDTH-1:0]  c_user_null  = USER_WIDTH'(3'b110);
    localparam logic [KEEP_WIDTH-1:0]  c_keep_dllp1 = KEEP_WIDTH'(4'b0011);
    localparam logic [KEEP_WIDTH-1:0]  c_keep_full  = {KEEP_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DLLP_HOLD = 3'd1,
        S_DLLP_OUT0 = 3'd2,
        S_DLLP_OUT1 = 3'd3,
        S_TLP       = 3'd4,
        S_DISCARD   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_hold0;
    logic [DATA_WIDTH-1:0] r_hold1;
    logic [c_cnt_w-1:0]    r_tlp_cnt;
    logic [c_cnt_w-1:0]    w_tlp_cnt_nxt;
    logic [c_cnt_w-1:0]    w_tlp_cnt_inc;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [KEEP_WIDTH-1:0] r_out_keep;
    logic                  r_out_last;
    logic [USER_WIDTH-1:0] r_out_user;

    logic                  w_out_free;
    logic                  w_s_ready;
    logic                  w_accept;
    logic                  w_sdp;
    logic                  w_stp;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [KEEP_WIDTH-1:0] w_load_keep;
    logic                  w_load_last;
    logic [USER_WIDTH-1:0] w_load_user;
    logic                  w_hold0_we;
    logic                  w_hold1_we;
    logic                  w_drop_inc;
    logic                  w_err_inc;
    logic                  w_tuser_unused;

    assign w_sdp          = s_axis_tuser[0];
    assign w_stp          = s_axis_tuser[1];
    assign w_tuser_unused = ^s_axis_tuser[USER_WIDTH-1:2];
    assign w_out_free     = !r_out_valid || m_axis_tready;
    assign w_tlp_cnt_inc  = r_tlp_cnt + c_cnt_w'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_s_ready     = 1'b0;
        w_accept      = 1'b0;
        w_load        = 1'b0;
        w_load_data   = s_axis_tdata;
        w_load_keep   = s_axis_tkeep;
        w_load_last   = s_axis_tlast;
        w_load_user   = c_user_tlp;
        w_hold0_we    = 1'b0;
        w_hold1_we    = 1'b0;
        w_tlp_cnt_nxt = r_tlp_cnt;
        w_drop_inc    = 1'b0;
        w_err_inc     = 1'b0;

        case (r_state)
            S_IDLE, S_DLLP_HOLD, S_TLP: w_s_ready = w_out_free;
            S_DISCARD:                  w_s_ready = 1'b1;
            default:                    w_s_ready = 1'b0;
        endcase
        w_accept = s_axis_tvalid && w_s_ready;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_sdp && !w_stp) begin
                        if (s_axis_tlast) begin
                            w_drop_inc = 1'b1;
                        end else begin
                            w_hold0_we  = 1'b1;
                            w_state_nxt = S_DLLP_HOLD;
                        end
                    end else if (w_stp && !w_sdp) begin
                        w_load        = 1'b1;
                        w_tlp_cnt_nxt = c_cnt_w'(1);
                        if (!s_axis_tlast) w_state_nxt = S_TLP;
                    end else begin
                        w_err_inc = 1'b1;
                        if (!s_axis_tlast) w_state_nxt = S_DISCARD;
                    end
                end
            end
            S_DLLP_HOLD: begin
                // Beat 0 goes straight to the output register when beat 1 validates.
                if (w_accept) begin
                    if (s_axis_tlast && (s_axis_tkeep == c_keep_dllp1)) begin
                        w_load      = 1'b1;
                        w_load_data = r_hold0;
                        w_load_keep = c_keep_full;
                        w_load_last = 1'b0;
                        w_load_user = c_user_dllp;
                        w_hold1_we  = 1'b1;
                        w_state_nxt = S_DLLP_OUT0;
                    end else begin
                        w_drop_inc  = 1'b1;
                        w_state_nxt = s_axis_tlast ? S_IDLE : S_DISCARD;
                    end
                end
            end
            S_DLLP_OUT0: begin
                if (m_axis_tready) begin
                    w_load      = 1'b1;
                    w_load_data = r_hold1;
                    w_load_keep = c_keep_dllp1;
                    w_load_last = 1'b1;
                    w_load_user = c_user_dllp;
                    w_state_nxt = S_DLLP_OUT1;
                end
            end
            S_DLLP_OUT1: begin
                if (m_axis_tready) w_state_nxt = S_IDLE;
            end
            S_TLP: begin
                if (w_accept) begin
                    w_load        = 1'b1;
                    w_tlp_cnt_nxt = w_tlp_cnt_inc;
                    if (w_tlp_cnt_inc > c_max_beats) begin
                        w_load_last = 1'b1;
                        w_load_user = c_user_null;
                        w_err_inc   = 1'b1;
                        w_state_nxt = s_axis_tlast ? S_IDLE : S_DISCARD;
                    end else if (s_axis_tlast) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (w_accept && s_axis_tlast) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Link down flushes the packet path and sinks input; statistics are kept.
        if (!phy_link_up_i) begin
            w_state_nxt = S_IDLE;
            w_s_ready   = 1'b1;
            w_load      = 1'b0;
            w_hold0_we  = 1'b0;
            w_hold1_we  = 1'b0;
            w_drop_inc  = 1'b0;
            w_err_inc   = 1'b0;
        end
        if (rst_i) w_s_ready = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !phy_link_up_i) begin
            r_state   <= S_IDLE;
            r_tlp_cnt <= '0;
            r_hold0   <= '0;
            r_hold1   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tlp_cnt <= w_tlp_cnt_nxt;
            if (w_hold0_we) r_hold0 <= s_axis_tdata;
            if (w_hold1_we) r_hold1 <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !phy_link_up_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_user  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_load_data;
            r_out_keep  <= w_load_keep;
            r_out_last  <= w_load_last;
            r_out_user  <= w_load_user;
        end else if (m_axis_tready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tkeep  = r_out_keep;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tuser  = r_out_user;

`ifdef PHY_RX_TAGGER_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
            if (w_err_inc  && (r_err_cnt  != 16'hFFFF)) r_err_cnt  <= r_err_cnt  + 16'd1;
        end
    end

    assign dllp_drop_cnt_o = r_drop_cnt;
    assign tlp_err_cnt_o   = r_err_cnt;
`else
    logic w_stats_unused;
    assign w_stats_unused  = w_drop_inc | w_err_inc;
    assign dllp_drop_cnt_o = '0;
    assign tlp_err_cnt_o   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_packet_tagger.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_rx_packet_tagger
// Brief    : Cycle-accurate vector table plus hand sequences for the tagger.
// Revision : 1.0
// ============================================================================
module tb_phy_rx_packet_tagger;

    localparam int         c_max_beats = 4;
    localparam logic [3:0] c_u_dllp    = 4'b0001;
    localparam logic [3:0] c_u_tlp     = 4'b0010;
    localparam logic [3:0] c_u_null    = 4'b0110;
    localparam logic [3:0] c_u_both    = 4'b0011;
`ifdef PHY_RX_TAGGER_STATS_EN
    localparam bit c_stats = 1'b1;
`else
    localparam bit c_stats = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        link;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic [3:0]  s_tuser;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic [3:0]  m_tuser;
    logic        m_tready;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    phy_rx_packet_tagger #(
        .DATA_WIDTH    (32),
        .KEEP_WIDTH    (4),
        .USER_WIDTH    (4),
        .MAX_TLP_BEATS (c_max_beats)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .phy_link_up_i   (link),
        .s_axis_tdata    (s_tdata),
        .s_axis_tkeep    (s_tkeep),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tlast    (s_tlast),
        .s_axis_tuser    (s_tuser),
        .s_axis_tready   (s_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tkeep    (m_tkeep),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tlast    (m_tlast),
        .m_axis_tuser    (m_tuser),
        .m_axis_tready   (m_tready),
        .dllp_drop_cnt_o (drop_cnt),
        .tlp_err_cnt_o   (err_cnt)
    );

    // One row = inputs held for one cycle and the outputs expected in that cycle.
    typedef struct {
        bit          link;
        bit          sv;
        logic [31:0] sd;
        logic [3:0]  sk;
        bit          sl;
        logic [3:0]  su;
        bit          mr;
        bit          e_sr;
        bit          e_mv;
        logic [31:0] e_md;
        logic [3:0]  e_mk;
        bit          e_ml;
        logic [3:0]  e_mu;
        int          e_drop;
        int          e_err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit lk, input bit sv, input logic [31:0] sd, input logic [3:0] sk,
                       input bit sl, input logic [3:0] su, input bit mr,
                       input bit e_sr, input bit e_mv, input logic [31:0] e_md, input logic [3:0] e_mk,
                       input bit e_ml, input logic [3:0] e_mu, input int e_drop, input int e_err);
        vec_t v;
        v.link = lk;   v.sv = sv;     v.sd = sd;     v.sk = sk;     v.sl = sl;
        v.su = su;     v.mr = mr;     v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md;
        v.e_mk = e_mk; v.e_ml = e_ml; v.e_mu = e_mu; v.e_drop = e_drop; v.e_err = e_err;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, got, want);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        link     = v.link;
        s_tvalid = v.sv;
        s_tdata  = v.sd;
        s_tkeep  = v.sk;
        s_tlast  = v.sl;
        s_tuser  = v.su;
        m_tready = v.mr;
        #1;
        chk("s_tready", idx, 32'(s_tready), 32'(v.e_sr));
        chk("m_tvalid", idx, 32'(m_tvalid), 32'(v.e_mv));
        if (v.e_mv) begin
            chk("m_tdata", idx, m_tdata, v.e_md);
            chk("m_tkeep", idx, 32'(m_tkeep), 32'(v.e_mk));
            chk("m_tlast", idx, 32'(m_tlast), 32'(v.e_ml));
            chk("m_tuser", idx, 32'(m_tuser), 32'(v.e_mu));
        end
        chk("drop_cnt", idx, 32'(drop_cnt), c_stats ? 32'(v.e_drop) : 32'd0);
        chk("err_cnt", idx, 32'(err_cnt), c_stats ? 32'(v.e_err) : 32'd0);
    endtask

    initial begin
        bit found;

        // Legal DLLP, output ready held high
        add(1,1,32'h00000000,4'hF,0,c_u_dllp,1, 1,0,32'h0,4'h0,0,4'h0, 0,0);
        add(1,1,32'h0000ABCD,4'h3,1,4'h0,1,     1,0,32'h0,4'h0,0,4'h0, 0,0);
        add(1,0,32'h0,4'h0,0,4'h0,1,            0,1,32'h00000000,4'hF,0,c_u_dllp, 0,0);
        add(1,0,32'h0,4'h0,0,4'h0,1,            0,1,32'h0000ABCD,4'h3,1,c_u_dllp, 0,0);
        add(1,0,32'h0,4'h0,0,4'h0,1,            1,0,32'h0,4'h0,0,4'h0, 0,0);
        // 3-beat TLP with output ready toggling
        add(1,1,32'h11111111,4'hF,0,c_u_tlp,1,  1,0,32'h0,4'h0,0,4'h0, 0,0);
        add(1,1,32'h22222222,4'hF,0,4'h0,0,     0,1,32'h11111111,4'hF,0,c_u_tlp, 0,0);
        add(1,1,32'h22222222,4'hF,0,4'h0,1,     1,1,32'h11111111,4'hF,0,c_u_tlp, 0,0);
        add(1,1,32'h33333333,4'hF,1,4'h0,0,     0,1,32'h22222222,4'hF,0,c_u_tlp, 0,0);
        add(1,1,32'h33333333,4'hF,1,4'h0,1,     1,1,32'h22222222,4'hF,0,c_u_tlp, 0,0);
        add(1,0,32'h0,4'h0,0,4'h0,0,            0,1,32'h33333333,4'hF,1,c_u_tlp, 0,0);
        add(1,0,32'h0,4'h0,0,4'h0,1,            1,1,32'h33333333,4'hF,1,c_u_tlp, 0,0);
        add(1,0,32'h0,4'h0,0,4'h0,1,            1,0,32'h0,4'h0,0,4'h0, 0,0);
        // DLLP with bad second-beat keep, then a 2-beat TLP
        add(1,1,32'hAAAA0001,4'hF,0,c_u_dllp,1, 1,0,32'h0,4'h0,0,4'h0, 0,0);
        add(1,1,32'hBBBB0002,4'hF,1,4'h0,1,     1,0,32'h0,4'h0,0,4'h0, 0,0);
        add(1,1,32'hCAFE0001,4'hF,0,c_u_tlp,1,  1,0,32'h0,4'h0,0,4'h0, 1,0);
        add(1,1,32'hCAFE0002,4'h7,1,4'h0,1,     1,1,32'hCAFE0001,4'hF,0,c_u_tlp, 1,0);
        add(1,0,32'h0,4'h0,0,4'h0,1,            1,1,32'hCAFE0002,4'h7,1,c_u_tlp, 1,0);
        add(1,0,32'h0,4'h0,0,4'h0,1,            1,0,32'h0,4'h0,0,4'h0, 1,0);
        // Overlong TLP: 7 beats against a 4-beat limit
        add(1,1,32'hE0000001,4'hF,0,c_u_tlp,1,  1,0,32'h0,4'h0,0,4'h0, 1,0);
        add(1,1,32'hE0000002,4'hF,0,4'h0,1,     1,1,32'hE0000001,4'hF,0,c_u_tlp, 1,0);
        add(1,1,32'hE0000003,4'hF,0,4'h0,1,     1,1,32'hE0000002,4'hF,0,c_u_tlp, 1,0);
        add(1,1,32'hE0000004,4'hF,0,4'h0,1,     1,1,32'hE0000003,4'hF,0,c_u_tlp, 1,0);
        add(1,1,32'hE0000005,4'hF,0,4'h0,1,     1,1,32'hE0000004,4'hF,0,c_u_tlp, 1,0);
        add(1,1,32'hE0000006,4'hF,0,4'h0,1,     1,1,32'hE0000005,4'hF,1,c_u_null, 1,1);
        add(1,1,32'hE0000007,4'hF,1,4'h0,1,     1,0,32'h0,4'h0,0,4'h0, 1,1);
        add(1,0,32'h0,4'h0,0,4'h0,1,            1,0,32'h0,4'h0,0,4'h0, 1,1);
        // Orphan packet, then a legal DLLP
        add(1,1,32'hDEAD0001,4'hF,0,4'h0,1,     1,0,32'h0,4'h0,0,4'h0, 1,1);
        add(1,1,32'hDEAD0002,4'hF,1,4'h0,1,     1,0,32'h0,4'h0,0,4'h0, 1,2);
        add(1,1,32'h12345678,4'hF,0,c_u_dllp,1, 1,0,32'h0,4'h0,0,4'h0, 1,2);
        add(1,1,32'h00009ABC,4'h3,1,4'h0,1,     1,0,32'h0,4'h0,0,4'h0, 1,2);
        add(1,0,32'h0,4'h0,0,4'h0,1,            0,1,32'h12345678,4'hF,0,c_u_dllp, 1,2);
        add(1,0,32'h0,4'h0,0,4'h0,1,            0,1,32'h00009ABC,4'h3,1,c_u_dllp, 1,2);
        add(1,0,32'h0,4'h0,0,4'h0,1,            1,0,32'h0,4'h0,0,4'h0, 1,2);
        // Single-beat packets: both markers, SDP-only, STP-only
        add(1,1,32'h00000000,4'hF,1,c_u_both,1, 1,0,32'h0,4'h0,0,4'h0, 1,2);
        add(1,1,32'h00000055,4'hF,1,c_u_dllp,1, 1,0,32'h0,4'h0,0,4'h0, 1,3);
        add(1,1,32'h77777777,4'hF,1,c_u_tlp,1,  1,0,32'h0,4'h0,0,4'h0, 2,3);
        add(1,0,32'h0,4'h0,0,4'h0,1,            1,1,32'h77777777,4'hF,1,c_u_tlp, 2,3);
        add(1,0,32'h0,4'h0,0,4'h0,1,            1,0,32'h0,4'h0,0,4'h0, 2,3);
        // DLLP output held off by downstream
        add(1,1,32'hA5A5A5A5,4'hF,0,c_u_dllp,0, 1,0,32'h0,4'h0,0,4'h0, 2,3);
        add(1,1,32'h00001234,4'h3,1,4'h0,0,     1,0,32'h0,4'h0,0,4'h0, 2,3);
        add(1,0,32'h0,4'h0,0,4'h0,0,            0,1,32'hA5A5A5A5,4'hF,0,c_u_dllp, 2,3);
        add(1,0,32'h0,4'h0,0,4'h0,0,            0,1,32'hA5A5A5A5,4'hF,0,c_u_dllp, 2,3);
        add(1,0,32'h0,4'h0,0,4'h0,1,            0,1,32'hA5A5A5A5,4'hF,0,c_u_dllp, 2,3);
        add(1,0,32'h0,4'h0,0,4'h0,0,            0,1,32'h00001234,4'h3,1,c_u_dllp, 2,3);
        add(1,0,32'h0,4'h0,0,4'h0,1,            0,1,32'h00001234,4'h3,1,c_u_dllp, 2,3);
        add(1,0,32'h0,4'h0,0,4'h0,1,            1,0,32'h0,4'h0,0,4'h0, 2,3);
        // Link drop in DLLP_HOLD: a following STP beat must be a fresh TLP
        add(1,1,32'h00000001,4'hF,0,c_u_dllp,1, 1,0,32'h0,4'h0,0,4'h0, 2,3);
        add(0,0,32'h0,4'h0,0,4'h0,1,            1,0,32'h0,4'h0,0,4'h0, 2,3);
        add(1,1,32'h0F0F0F0F,4'hF,1,c_u_tlp,1,  1,0,32'h0,4'h0,0,4'h0, 2,3);
        add(1,0,32'h0,4'h0,0,4'h0,1,            1,1,32'h0F0F0F0F,4'hF,1,c_u_tlp, 2,3);
        add(1,0,32'h0,4'h0,0,4'h0,1,            1,0,32'h0,4'h0,0,4'h0, 2,3);
        // Link drop with a stalled output beat
        add(1,1,32'h5A5A0001,4'hF,0,c_u_tlp,0,  1,0,32'h0,4'h0,0,4'h0, 2,3);
        add(1,0,32'h0,4'h0,0,4'h0,0,            0,1,32'h5A5A0001,4'hF,0,c_u_tlp, 2,3);
        add(0,0,32'h0,4'h0,0,4'h0,0,            1,1,32'h5A5A0001,4'hF,0,c_u_tlp, 2,3);
        add(1,0,32'h0,4'h0,0,4'h0,0,            1,0,32'h0,4'h0,0,4'h0, 2,3);

        rst      = 1'b1;
        link     = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        m_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_s_tready", 0, 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 0, 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", 0, m_tdata, 32'd0);
        chk("rst_m_tkeep", 0, 32'(m_tkeep), 32'd0);
        chk("rst_m_tlast", 0, 32'(m_tlast), 32'd0);
        chk("rst_m_tuser", 0, 32'(m_tuser), 32'd0);
        chk("rst_drop_cnt", 0, 32'(drop_cnt), 32'd0);
        chk("rst_err_cnt", 0, 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) run_vec(i, vq[i]);

        // Two-beat TLP; wait a bounded number of cycles for its last beat.
        @(negedge clk);
        link = 1'b1; m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 32'h600D0001; s_tkeep = 4'hF; s_tlast = 1'b0; s_tuser = c_u_tlp;
        @(negedge clk);
        s_tdata = 32'h600D0002; s_tlast = 1'b1; s_tuser = 4'h0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            s_tvalid = 1'b0;
            #1;
            if (m_tvalid && m_tlast) begin
                found = 1'b1;
                chk("tail_tdata", k, m_tdata, 32'h600D0002);
                chk("tail_tuser", k, 32'(m_tuser), 32'(c_u_tlp));
            end
        end
        chk("tail_seen", 0, 32'(found), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
